phase_seq_monitor: RTL and testbench



---
 rtl/phase_seq_monitor_pkg.sv | 20 ++
 rtl/phase_seq_monitor_if.sv | 30 +++
 rtl/phase_seq_monitor_onehot4_decode.sv | 22 ++
 rtl/phase_seq_monitor.sv | 127 ++++++++++++
 tb/tb_phase_seq_monitor.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/phase_seq_monitor_pkg.sv
// Shared types and constants for the four-phase strobe monitor.
// Holds the FSM state encoding and the strobe-sample classification.
package phase_mon_pkg;

    localparam int NUM_PHASES = 4;
    localparam int IDX_W      = $clog2(NUM_PHASES);

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKING,
        LOCKED
    } mon_state_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_ONE,
        CLS_MULTI
    } phase_cls_e;

endpackage

// File: rtl/phase_seq_monitor_if.sv
// Strobe inputs and status outputs of the phase-sequence monitor.
// The master drives the strobes; the slave (monitor) reports status.
interface phase_seq_monitor_if #(
    parameter int ERR_CNT_W = 8,
    parameter int ROT_CNT_W = 16
);
    logic                 clk1_in;
    logic                 clk2_in;
    logic                 clk3_in;
    logic                 clk4_in;
    logic [1:0]           phase_idx;
    logic                 phase_valid;
    logic                 locked;
    logic                 seq_err;
    logic [ERR_CNT_W-1:0] err_count;
    logic [ROT_CNT_W-1:0] rot_count;
    logic                 rot_tick;

    modport master (
        output clk1_in, clk2_in, clk3_in, clk4_in,
        input  phase_idx, phase_valid, locked, seq_err,
        input  err_count, rot_count, rot_tick
    );

    modport slave (
        input  clk1_in, clk2_in, clk3_in, clk4_in,
        output phase_idx, phase_valid, locked, seq_err,
        output err_count, rot_count, rot_tick
    );
endinterface

// File: rtl/phase_seq_monitor_onehot4_decode.sv
// Combinational classifier for a 4-bit strobe sample: none / one-hot / multi,
// plus the bit position when exactly one strobe is set.
module onehot4_decode
    import phase_mon_pkg::*;
(
    input  logic [3:0]       i_strobe,
    output phase_cls_e       o_cls,
    output logic [IDX_W-1:0] o_idx
);
    always_comb begin
        o_cls = CLS_MULTI;
        o_idx = '0;
        case (i_strobe)
            4'b0000: o_cls = CLS_NONE;
            4'b0001: begin o_cls = CLS_ONE; o_idx = IDX_W'(0); end
            4'b0010: begin o_cls = CLS_ONE; o_idx = IDX_W'(1); end
            4'b0100: begin o_cls = CLS_ONE; o_idx = IDX_W'(2); end
            4'b1000: begin o_cls = CLS_ONE; o_idx = IDX_W'(3); end
            default: o_cls = CLS_MULTI;
        endcase
    end
endmodule

// File: rtl/phase_seq_monitor.sv
// Receiver-side monitor for four one-hot phase strobes: decodes the phase,
// checks rotation order, locks after a good run and counts errors/rotations.
module phase_seq_monitor
    import phase_mon_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int ROT_CNT_W  = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    phase_seq_monitor_if.slave mon_if
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    logic [3:0]           w_strobe;
    phase_cls_e           w_cls;
    logic [IDX_W-1:0]     w_idx;
    logic [IDX_W-1:0]     w_expected;
    logic                 w_one;
    logic                 w_in_order;
    logic [GOOD_W-1:0]    w_good_inc;

    mon_state_e           r_state_p1;
    logic [GOOD_W-1:0]    r_good_cnt_p1;
    logic [IDX_W-1:0]     r_last_idx_p1;
    logic                 r_vld_p1;
    logic                 r_locked_p1;
    logic                 r_seq_err_p1;
    logic                 r_rot_tick_p1;
    logic [ERR_CNT_W-1:0] r_err_cnt_p1;
    logic [ROT_CNT_W-1:0] r_rot_cnt_p1;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    assign w_strobe = {mon_if.clk4_in, mon_if.clk3_in, mon_if.clk2_in, mon_if.clk1_in};

    onehot4_decode u_decode (
        .i_strobe (w_strobe),
        .o_cls    (w_cls),
        .o_idx    (w_idx)
    );

    // Expected index wraps naturally because IDX_W covers exactly NUM_PHASES.
    assign w_expected = r_last_idx_p1 + IDX_W'(1);
    assign w_one      = (w_cls == CLS_ONE);
    assign w_in_order = w_one && (w_idx == w_expected);
    assign w_good_inc = r_good_cnt_p1 + GOOD_W'(1);

    // Stage p1: every output is registered from the current strobe sample.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state_p1    <= UNLOCKED;
            r_good_cnt_p1 <= '0;
            r_last_idx_p1 <= '0;
            r_vld_p1      <= 1'b0;
            r_locked_p1   <= 1'b0;
            r_seq_err_p1  <= 1'b0;
            r_rot_tick_p1 <= 1'b0;
            r_err_cnt_p1  <= '0;
            r_rot_cnt_p1  <= '0;
        end else begin
            r_vld_p1      <= w_one;
            r_seq_err_p1  <= 1'b0;
            r_rot_tick_p1 <= 1'b0;
            if (w_one) r_last_idx_p1 <= w_idx;

            case (r_state_p1)
                UNLOCKED: begin
                    if (w_one) begin
                        r_good_cnt_p1 <= GOOD_W'(1);
                        r_state_p1    <= LOCKING;
                    end
                end
                LOCKING: begin
                    if (w_in_order) begin
                        r_good_cnt_p1 <= w_good_inc;
                        if (w_good_inc == GOOD_W'(LOCK_COUNT)) begin
                            r_state_p1  <= LOCKED;
                            r_locked_p1 <= 1'b1;
                        end
                    end else if (w_one) begin
                        r_good_cnt_p1 <= GOOD_W'(1);
                    end else begin
                        r_good_cnt_p1 <= '0;
                        r_state_p1    <= UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (w_in_order) begin
                        if (w_idx == IDX_W'(NUM_PHASES - 1)) begin
                            r_rot_tick_p1 <= 1'b1;
                            r_rot_cnt_p1  <= r_rot_cnt_p1 + ROT_CNT_W'(1);
                        end
                    end else begin
                        r_seq_err_p1 <= 1'b1;
                        r_err_cnt_p1 <= sat_inc(r_err_cnt_p1);
                        r_locked_p1  <= 1'b0;
                        if (w_one) begin
                            r_good_cnt_p1 <= GOOD_W'(1);
                            r_state_p1    <= LOCKING;
                        end else begin
                            r_good_cnt_p1 <= '0;
                            r_state_p1    <= UNLOCKED;
                        end
                    end
                end
                default: begin
                    r_state_p1    <= UNLOCKED;
                    r_good_cnt_p1 <= '0;
                    r_locked_p1   <= 1'b0;
                end
            endcase
        end
    end

    assign mon_if.phase_idx   = r_last_idx_p1;
    assign mon_if.phase_valid = r_vld_p1;
    assign mon_if.locked      = r_locked_p1;
    assign mon_if.seq_err     = r_seq_err_p1;
    assign mon_if.err_count   = r_err_cnt_p1;
    assign mon_if.rot_count   = r_rot_cnt_p1;
    assign mon_if.rot_tick    = r_rot_tick_p1;

endmodule

// File: tb/tb_phase_seq_monitor.sv
// Scoreboard bench for phase_seq_monitor with small counter widths so that
// error saturation and rotation wrap are reachable quickly.
module tb_phase_seq_monitor;
    localparam int LOCK_COUNT = 4;
    localparam int ERR_W      = 2;
    localparam int ROT_W      = 2;

    typedef struct {
        int idx;
        int valid;
        int locked;
        int seq_err;
        int err;
        int rot;
        int tick;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sbq[$];

    // reference model state: 0 unlocked, 1 locking, 2 locked
    int m_state, m_good, m_last, m_err, m_rot;

    phase_seq_monitor_if #(.ERR_CNT_W(ERR_W), .ROT_CNT_W(ROT_W)) mif ();

    phase_seq_monitor #(
        .LOCK_COUNT (LOCK_COUNT),
        .ERR_CNT_W  (ERR_W),
        .ROT_CNT_W  (ROT_W)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .mon_if (mif)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_t e;
        m_state = 0; m_good = 0; m_last = 0; m_err = 0; m_rot = 0;
        e = '{idx: 0, valid: 0, locked: 0, seq_err: 0, err: 0, rot: 0, tick: 0};
        sbq.push_back(e);
    endtask

    task automatic model_step(input logic [3:0] s);
        exp_t e;
        int   idx, expd;
        bit   one;
        one  = ($countones(s) == 1);
        idx  = s[1] ? 1 : s[2] ? 2 : s[3] ? 3 : 0;
        expd = (m_last + 1) % 4;
        e.seq_err = 0;
        e.tick    = 0;
        if (m_state == 0) begin
            if (one) begin m_good = 1; m_state = 1; end
        end else if (m_state == 1) begin
            if (one && idx == expd) begin
                m_good++;
                if (m_good == LOCK_COUNT) m_state = 2;
            end else if (one) begin
                m_good = 1;
            end else begin
                m_good = 0; m_state = 0;
            end
        end else begin
            if (one && idx == expd) begin
                if (idx == 3) begin
                    e.tick = 1;
                    m_rot  = (m_rot + 1) % (1 << ROT_W);
                end
            end else begin
                e.seq_err = 1;
                if (m_err < (1 << ERR_W) - 1) m_err++;
                if (one) begin m_good = 1; m_state = 1; end
                else     begin m_good = 0; m_state = 0; end
            end
        end
        if (one) m_last = idx;
        e.idx    = m_last;
        e.valid  = one ? 1 : 0;
        e.locked = (m_state == 2) ? 1 : 0;
        e.err    = m_err;
        e.rot    = m_rot;
        sbq.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sbq.size() == 0) begin
            check_eq("sb_empty", 0, 1);
            return;
        end
        e = sbq.pop_front();
        check_eq("phase_idx",   int'(mif.phase_idx),   e.idx);
        check_eq("phase_valid", int'(mif.phase_valid), e.valid);
        check_eq("locked",      int'(mif.locked),      e.locked);
        check_eq("seq_err",     int'(mif.seq_err),     e.seq_err);
        check_eq("err_count",   int'(mif.err_count),   e.err);
        check_eq("rot_count",   int'(mif.rot_count),   e.rot);
        check_eq("rot_tick",    int'(mif.rot_tick),    e.tick);
        check_eq("err_tick_excl", int'(mif.seq_err & mif.rot_tick), 0);
    endtask

    task automatic set_strobes(input logic [3:0] s);
        {mif.clk4_in, mif.clk3_in, mif.clk2_in, mif.clk1_in} = s;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        set_strobes(4'b0000);
        model_reset();
        @(posedge clk_in); #1;
        compare_front();
        rst_in = 1'b0;
    endtask

    task automatic send(input logic [3:0] s);
        @(negedge clk_in);
        set_strobes(s);
        model_step(s);
        @(posedge clk_in); #1;
        compare_front();
    endtask

    task automatic send_idx(input int i);
        logic [3:0] s;
        s = 4'b0001 << i;
        send(s);
    endtask

    task automatic rotation();
        for (int i = 0; i < 4; i++) send_idx(i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] s;
        int         r;
        set_strobes(4'b0000);
        // reset held across a couple of edges, outputs all zero
        do_reset();

        // clean rotations: lock on 4th sample, first tick on 8th
        for (int i = 0; i < 3; i++) send_idx(i);
        check_eq("not_locked_yet", int'(mif.locked), 0);
        send_idx(3);
        check_eq("locked_on_4th", int'(mif.locked), 1);
        rotation();
        check_eq("rot_after_8", int'(mif.rot_count), 1);

        // out-of-order while locked, then relock after 3 more
        send_idx(0);
        send_idx(2);
        check_eq("ooo_err_cnt", int'(mif.err_count), 1);
        send_idx(3); send_idx(0); send_idx(1);
        check_eq("relocked", int'(mif.locked), 1);

        // all-zero sample while locked: phase_idx holds
        send_idx(2);
        send(4'b0000);
        check_eq("hold_idx", int'(mif.phase_idx), 2);
        check_eq("none_unlocked", int'(mif.locked), 0);

        // multi-hot while unlocked: no error, stays unlocked
        for (int i = 0; i < 3; i++) send(4'b0101);
        check_eq("multi_err_cnt", int'(mif.err_count), 2);

        // repeated lock/break: error counter saturates at 3
        for (int k = 0; k < 3; k++) begin
            rotation();
            send(4'b0000);
        end
        check_eq("err_saturated", int'(mif.err_count), 3);

        // locked with nonzero counters, then reset mid-operation
        rotation();
        rotation();
        rotation();
        do_reset();
        check_eq("rst_locked", int'(mif.locked), 0);
        check_eq("rst_rot", int'(mif.rot_count), 0);

        // relock takes LOCK_COUNT samples, then 5 rotations wrap to 1
        rotation();
        for (int k = 0; k < 5; k++) rotation();
        check_eq("rot_wrapped", int'(mif.rot_count), 1);

        // mixed random traffic against the model
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       s = 4'b0001 << ((m_last + 1) % 4);
            else if (r < 8)  s = 4'b0001 << $urandom_range(0, 3);
            else if (r == 8) s = 4'b0000;
            else             s = 4'($urandom_range(0, 15));
            send(s);
        end

        check_eq("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
